// File: rtl/timer_tick_sequencer_if.sv
// Avalon-MM write-only link between the tick sequencer (master) and the interval timer (slave).
// The timer's level interrupt travels back to the master on the same bundle.
interface timer_tick_sequencer_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [DATA_W-1:0] tmr_writedata;
    logic              tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_tick_sequencer.sv
// Programs and starts the interval timer, clears each timeout irq, and divides the
// serviced irq stream into a one-cycle seconds strobe with a running tick count.
module timer_tick_sequencer #(
    parameter logic [31:0] PERIOD    = 32'd49999,
    parameter int unsigned DIV_TICKS = 1000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    timer_tick_sequencer_if.master        tmr,
    output logic                          sec_pulse,
    output logic [15:0]                   tick_count,
    output logic                          running,
    output logic                          overrun
);
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TICK_W = 16;

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PER_L  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PER_H  = ADDR_W'(3);

    localparam logic [DATA_W-1:0] CTRL_GO   = DATA_W'(16'h0007);
    localparam logic [DATA_W-1:0] CTRL_STOP = DATA_W'(16'h0008);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_TICKS - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR,
        S_CLR_WAIT,
        S_WR_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                pulse_q, pulse_d;
    logic                ovr_q, ovr_d;
    logic                run_q, run_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Next state plus registered outputs decoded from the state being entered,
    // so every bus write lines up with the cycle its state is occupied.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        ovr_d   = ovr_q;
        pulse_d = 1'b0;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wdata_d = '0;

        case (state_q)
            S_IDLE:    if (enable) state_d = S_WR_PL;
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_RUN;
            S_RUN: begin
                if (!enable) begin
                    state_d = S_WR_STOP;
                end else if (tmr.tmr_irq) begin
                    state_d = S_CLR;
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_CLR:     state_d = S_CLR_WAIT;
            S_CLR_WAIT: begin
                if (tmr.tmr_irq) ovr_d = 1'b1;
                state_d = enable ? S_RUN : S_WR_STOP;
            end
            S_WR_STOP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        case (state_d)
            S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PER_L;  wdata_d = PERIOD[15:0];  end
            S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PER_H;  wdata_d = PERIOD[31:16]; end
            S_WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CTRL;   wdata_d = CTRL_GO;       end
            S_CLR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS; wdata_d = '0;            end
            S_WR_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CTRL;   wdata_d = CTRL_STOP;     end
            default:   ;
        endcase

        run_d = (state_d == S_RUN) || (state_d == S_CLR) || (state_d == S_CLR_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            pulse_q <= 1'b0;
            ovr_q   <= 1'b0;
            run_q   <= 1'b0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
            ovr_q   <= ovr_d;
            run_q   <= run_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_writedata  = wdata_q;
    assign sec_pulse          = pulse_q;
    assign tick_count         = tick_q;
    assign running            = run_q;
    assign overrun            = ovr_q;
endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Scoreboarded random bench for timer_tick_sequencer: stimulus tasks push the expected
// timer writes, a monitor pops and compares them as the DUT drives the bus.
module tb_timer_tick_sequencer;
    localparam logic [31:0] PERIOD    = 32'd49999;
    localparam int unsigned DIV_TICKS = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sec_pulse;
    logic [15:0] tick_count;
    logic        running;
    logic        overrun;

    timer_tick_sequencer_if tmr_if ();

    timer_tick_sequencer #(.PERIOD(PERIOD), .DIV_TICKS(DIV_TICKS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .tmr        (tmr_if),
        .sec_pulse  (sec_pulse),
        .tick_count (tick_count),
        .running    (running),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        is_clr;
        logic [15:0] tick;
        logic        pulse;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;

    // reference state: serviced irq count modulo the divider, sticky overrun, run level
    int   model_tick  = 0;
    bit   model_ovr   = 1'b0;
    bit   model_run   = 1'b0;
    bit   irq_pending = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e = '0;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_clr();
        exp_t e;
        model_tick = (model_tick + 1) % DIV_TICKS;
        e = '0;
        e.addr   = 3'd0;
        e.data   = 16'h0000;
        e.is_clr = 1'b1;
        e.tick   = 16'(model_tick);
        e.pulse  = (model_tick == 0);
        e.ovr    = model_ovr;
        exp_q.push_back(e);
    endtask

    task automatic push_program();
        push_wr(3'd2, PERIOD[15:0]);
        push_wr(3'd3, PERIOD[31:16]);
        push_wr(3'd1, 16'h0007);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // acts as the timer slave: waits (bounded) for a status-clear write
    task automatic wait_clear(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tmr_if.tmr_chipselect && !tmr_if.tmr_write_n && tmr_if.tmr_address == 3'd0) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_start();
        bit seen;
        enable = 1'b1;
        push_program();
        if (irq_pending) begin
            push_clr();
            wait_clear(seen);
            check("pending_clear_seen", 32'(seen), 32'd1);
            tmr_if.tmr_irq = 1'b0;
            irq_pending = 1'b0;
        end
        settle(6);
        model_run = 1'b1;
        check("running_after_start", 32'(running), 32'(model_run));
    endtask

    task automatic do_stop(input bit with_irq);
        if (with_irq) begin
            tmr_if.tmr_irq = 1'b1;
            irq_pending = 1'b1;
        end
        enable = 1'b0;
        push_wr(3'd1, 16'h0008);
        settle(4);
        model_run = 1'b0;
        check("running_after_stop", 32'(running), 32'(model_run));
        check("tick_kept_after_stop", 32'(tick_count), 32'(model_tick));
    endtask

    task automatic do_irq(input bit hold);
        bit seen;
        tmr_if.tmr_irq = 1'b1;
        push_clr();
        if (hold) begin
            model_ovr = 1'b1;
            push_clr();
        end
        wait_clear(seen);
        check("clear_seen", 32'(seen), 32'd1);
        if (hold) begin
            wait_clear(seen);
            check("second_clear_seen", 32'(seen), 32'd1);
        end
        tmr_if.tmr_irq = 1'b0;
        settle(3);
        check("overrun_level", 32'(overrun), 32'(model_ovr));
        check("running_in_run", 32'(running), 32'(model_run));
    endtask

    task automatic start_abort(input int k);
        enable = 1'b1;
        push_program();
        push_wr(3'd1, 16'h0008);
        settle(k);
        enable = 1'b0;
        settle(6);
        check("running_after_abort", 32'(running), 32'(model_run));
    endtask

    task automatic reset_in_clr();
        bit seen;
        tmr_if.tmr_irq = 1'b1;
        push_clr();
        wait_clear(seen);
        check("clear_before_reset", 32'(seen), 32'd1);
        reset_n = 1'b0;
        tmr_if.tmr_irq = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        model_tick = 0;
        model_ovr  = 1'b0;
        model_run  = 1'b0;
        irq_pending = 1'b0;
        check("rst_cs", 32'(tmr_if.tmr_chipselect), 32'd0);
        check("rst_write_n", 32'(tmr_if.tmr_write_n), 32'd1);
        check("rst_tick", 32'(tick_count), 32'(model_tick));
        check("rst_running", 32'(running), 32'(model_run));
        check("rst_overrun", 32'(overrun), 32'(model_ovr));
        check("rst_sec_pulse", 32'(sec_pulse), 32'd0);
        reset_n = 1'b1;
        settle(2);
    endtask

    // monitor: every bus write must match the head of the scoreboard; idle cycles must be quiet
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (tmr_if.tmr_chipselect) begin
                check("write_n_with_cs", 32'(tmr_if.tmr_write_n), 32'd0);
                if (exp_q.size() == 0) begin
                    check("writes_outstanding", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(tmr_if.tmr_address), 32'(e.addr));
                    check("wr_data", 32'(tmr_if.tmr_writedata), 32'(e.data));
                    if (e.is_clr) begin
                        check("clr_tick_count", 32'(tick_count), 32'(e.tick));
                        check("clr_sec_pulse", 32'(sec_pulse), 32'(e.pulse));
                        check("clr_overrun", 32'(overrun), 32'(e.ovr));
                    end else begin
                        check("sec_pulse_quiet", 32'(sec_pulse), 32'd0);
                    end
                end
            end else begin
                check("idle_write_n", 32'(tmr_if.tmr_write_n), 32'd1);
                check("idle_addr", 32'(tmr_if.tmr_address), 32'd0);
                check("idle_data", 32'(tmr_if.tmr_writedata), 32'd0);
                check("idle_sec_pulse", 32'(sec_pulse), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        reset_n = 1'b0;
        enable  = 1'b0;
        tmr_if.tmr_irq = 1'b0;
        settle(2);
        check("reset_cs", 32'(tmr_if.tmr_chipselect), 32'd0);
        check("reset_write_n", 32'(tmr_if.tmr_write_n), 32'd1);
        check("reset_addr", 32'(tmr_if.tmr_address), 32'd0);
        check("reset_data", 32'(tmr_if.tmr_writedata), 32'd0);
        check("reset_tick", 32'(tick_count), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        settle(2);

        do_start();
        for (int i = 0; i < 6; i++) do_irq(1'b0);
        do_irq(1'b1);
        do_stop(1'b0);
        start_abort(2);
        do_start();
        do_stop(1'b1);
        do_start();
        reset_in_clr();

        for (int i = 0; i < 40; i++) begin
            if (model_run) begin
                r = int'($urandom_range(0, 9));
                if (r <= 4)      do_irq(1'b0);
                else if (r == 5) do_irq(1'b1);
                else if (r <= 7) do_stop(1'b0);
                else if (r == 8) do_stop(1'b1);
                else             reset_in_clr();
            end else begin
                r = int'($urandom_range(0, 4));
                if (r <= 3) do_start();
                else        start_abort(int'($urandom_range(1, 3)));
            end
        end
        if (model_run) do_stop(1'b0);
        settle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
